// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-pacing state encoding used by the echo buffer.
package uart_pkg;

   localparam int BIT_CYCLES_50M_9600 = 5208;
   localparam int UART_FRAME_BITS     = 11;
   localparam int UART_START_HOLD     = 4;
   localparam int UART_FIFO_DEPTH     = 16;

   typedef enum logic [2:0] {
      TX_IDLE = 3'd0,
      TX_LOAD = 3'd1,
      TX_HOLD = 3'd2,
      TX_FIRE = 3'd3,
      TX_WAIT = 3'd4
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO; push and pop in one cycle are both honoured, even when full.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop & (r_count != '0);
   assign w_push = push & ((r_count != FULL_CNT) | w_pop);

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == FULL_CNT);
   assign empty = (r_count == '0);
   assign count = r_count;

   // Storage carries no reset; emptiness is defined by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo buffer between UART wrapper and application: RX edge detect, RX/local arbitration,
// sticky overflow flag and a paced transmit FSM that spaces bytes one frame apart.
module uart_echo_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_FIFO_DEPTH,
   parameter int BIT_CYCLES = BIT_CYCLES_50M_9600,
   parameter int FRAME_BITS = UART_FRAME_BITS,
   parameter int START_HOLD = UART_START_HOLD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx_start,
   input  logic [7:0]               recivedata,
   output logic [7:0]               putdata,
   output logic                     tx_start,
   input  logic [7:0]               loc_data,
   input  logic                     loc_valid,
   output logic                     loc_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     tx_busy,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS;
   localparam int FW           = $clog2(FRAME_CYCLES);
   localparam int HW           = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   // FIRE is the first cycle of the frame, so WAIT covers the remaining FRAME_CYCLES-1.
   localparam logic [FW-1:0] WAIT_LAST = FW'(FRAME_CYCLES - 2);
   localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

   logic                      r_s1;
   logic                      r_s2;
   logic                      r_s3;
   logic                      w_rx_fall;

   logic                      w_full;
   logic                      w_empty;
   logic [7:0]                w_head;
   logic [$clog2(DEPTH):0]    w_count;
   logic                      w_pop;
   logic                      w_push;
   logic [7:0]                w_din;
   logic                      w_loc_ready;
   logic                      w_rx_push;
   logic                      w_rx_drop;
   logic                      w_loc_push;

   tx_state_e                 r_state;
   logic [HW-1:0]             r_hold_cnt;
   logic [FW-1:0]             r_frame_cnt;
   logic [7:0]                r_putdata;
   logic                      r_tx_start;
   logic                      r_tx_busy;
   logic                      r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= rx_start;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rx_fall = r_s3 & ~r_s2;

   // RX wins any collision; a local byte waits for a cycle without an RX push.
   assign w_pop       = (r_state == TX_LOAD);
   assign w_loc_ready = ~w_rx_fall & (~w_full | w_pop);
   assign w_rx_push   = w_rx_fall & (~w_full | w_pop);
   assign w_rx_drop   = w_rx_fall & w_full & ~w_pop;
   assign w_loc_push  = loc_valid & w_loc_ready;
   assign w_push      = w_rx_push | w_loc_push;
   assign w_din       = w_rx_fall ? recivedata : loc_data;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_rx_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= TX_IDLE;
         r_hold_cnt  <= '0;
         r_frame_cnt <= '0;
         r_putdata   <= 8'h00;
         r_tx_start  <= 1'b0;
         r_tx_busy   <= 1'b0;
      end else begin
         case (r_state)
            TX_IDLE: begin
               if (!w_empty) begin
                  r_state   <= TX_LOAD;
                  r_tx_busy <= 1'b1;
               end
            end
            TX_LOAD: begin
               r_putdata  <= w_head;
               r_tx_start <= 1'b1;
               r_hold_cnt <= '0;
               r_state    <= TX_HOLD;
            end
            TX_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_tx_start <= 1'b0;
                  r_state    <= TX_FIRE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            TX_FIRE: begin
               r_frame_cnt <= '0;
               r_state     <= TX_WAIT;
            end
            TX_WAIT: begin
               if (r_frame_cnt == WAIT_LAST) begin
                  r_state   <= TX_IDLE;
                  r_tx_busy <= 1'b0;
               end else begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= TX_IDLE;
               r_tx_start <= 1'b0;
               r_tx_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign putdata    = r_putdata;
   assign tx_start   = r_tx_start;
   assign tx_busy    = r_tx_busy;
   assign overflow   = r_overflow;
   assign loc_ready  = w_loc_ready;
   assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: queue/timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized RX/local traffic.
module tb_uart_echo_buffer;

   localparam int DEPTH  = 16;
   localparam int BITC   = 4;
   localparam int FRAMEB = 11;
   localparam int HOLD   = 4;
   localparam int F      = BITC * FRAMEB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx_start = 1'b0;
   logic [7:0] recivedata = 8'h00;
   logic [7:0] loc_data = 8'h00;
   logic       loc_valid = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] putdata;
   logic       tx_start;
   logic       loc_ready;
   logic [4:0] fifo_count;
   logic       tx_busy;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   uart_echo_buffer #(
      .DEPTH      (DEPTH),
      .BIT_CYCLES (BITC),
      .FRAME_BITS (FRAMEB),
      .START_HOLD (HOLD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_start   (rx_start),
      .recivedata (recivedata),
      .putdata    (putdata),
      .tx_start   (tx_start),
      .loc_data   (loc_data),
      .loc_valid  (loc_valid),
      .loc_ready  (loc_ready),
      .fifo_count (fifo_count),
      .tx_busy    (tx_busy),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference model: byte queue plus a transmit timeline. m_phase is the number of
   // cycles since the LOAD cycle of the byte in flight (-1 when nothing is in flight).
   // One byte occupies LOAD + HOLD high cycles + FRAME cycles counted from the tx_start fall.
   logic [7:0] m_q[$];
   int         m_phase = -1;
   logic [7:0] m_put = 8'h00;
   logic       m_ovf = 1'b0;
   logic       m_d1 = 1'b0;
   logic       m_d2 = 1'b0;
   logic       m_d3 = 1'b0;
   logic       m_fall;
   logic       m_pop;
   logic       m_full;
   logic       m_lready;
   int         m_sz;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_phase = -1;
         m_put = 8'h00;
         m_ovf = 1'b0;
         m_d1 = 1'b0;
         m_d2 = 1'b0;
         m_d3 = 1'b0;
      end
      m_fall   = m_d3 & ~m_d2;
      m_pop    = (m_phase == 0);
      m_sz     = m_q.size();
      m_full   = (m_sz == DEPTH);
      m_lready = ~m_fall & (~m_full | m_pop);
      chk("m_count", 32'(fifo_count), m_sz);
      chk("m_putdata", 32'(putdata), 32'(m_put));
      chk("m_tx_start", 32'(tx_start), 32'(m_phase >= 1 && m_phase <= HOLD));
      chk("m_tx_busy", 32'(tx_busy), 32'(m_phase >= 0));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_loc_ready", 32'(loc_ready), 32'(m_lready));
      if (rst_n) begin
         if (m_pop) m_put = m_q.pop_front();
         if (m_fall) begin
            if (!m_full || m_pop) m_q.push_back(recivedata);
            else m_ovf = 1'b1;
         end else if (loc_valid && m_lready) begin
            m_q.push_back(loc_data);
         end
         if (ovf_clr && !(m_fall && m_full && !m_pop)) m_ovf = 1'b0;
         if (m_phase >= 0) m_phase = (m_phase == F + HOLD) ? -1 : m_phase + 1;
         else if (m_sz > 0) m_phase = 0;
         m_d3 = m_d2;
         m_d2 = m_d1;
         m_d1 = rx_start;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fall(input string name, output time t);
      logic prev;
      prev = tx_start;
      t = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (prev && !tx_start) begin
            t = $time;
            break;
         end
         prev = tx_start;
      end
      chk(name, 32'(t != 0), 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 2000 && !(tx_busy == 1'b0 && fifo_count == 5'd0)) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n >= 2000), 0);
      tick();
   endtask

   initial begin
      time t1, t2, t3;
      int  hi;
      bit  got;

      // 1. reset values
      #2 rst_n = 1'b0;
      tick(); tick(); tick();
      chk("rst_putdata", 32'(putdata), 32'h00);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_loc_ready", 32'(loc_ready), 1);
      rst_n = 1'b1;
      tick(); tick();

      // 2. RX echo
      recivedata = 8'hA5;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      tick(); tick();
      chk("echo_count_2cyc", 32'(fifo_count), 0);
      tick();
      chk("echo_count_3cyc", 32'(fifo_count), 1);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_start) hi++;
         else if (hi > 0) break;
      end
      chk("echo_hold_len", hi, 4);
      chk("echo_putdata", 32'(putdata), 32'hA5);
      wait_idle("echo_idle_timeout");

      // 3. pacing of three quick local bytes
      loc_valid = 1'b1;
      loc_data = 8'h01; tick();
      loc_data = 8'h02; tick();
      loc_data = 8'h03; tick();
      loc_valid = 1'b0;
      wait_fall("pace_fall1", t1); chk("pace_data1", 32'(putdata), 32'h01);
      wait_fall("pace_fall2", t2); chk("pace_data2", 32'(putdata), 32'h02);
      wait_fall("pace_fall3", t3); chk("pace_data3", 32'(putdata), 32'h03);
      chk("pace_gap12", 32'((t2 - t1) / 10), 50);
      chk("pace_gap23", 32'((t3 - t2) / 10), 50);
      wait_idle("pace_idle_timeout");

      // 4. overflow: 17 RX bytes while the transmitter sits in its frame wait
      loc_valid = 1'b1; loc_data = 8'h10; tick();
      loc_valid = 1'b0;
      wait_fall("ovf_fall", t1);
      tick();
      for (int j = 0; j < 2 * 17 + 3; j++) begin
         rx_start = (j < 2 * 17) ? (j % 2 == 0) : 1'b0;
         if (j >= 3) recivedata = 8'h20 + 8'((j - 3) / 2);
         tick();
      end
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_count", 32'(fifo_count), 16);
      chk("ovf_busy", 32'(tx_busy), 1);
      ovf_clr = 1'b1; tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);

      // 6. full FIFO: local byte accepted only in the popping cycle
      loc_valid = 1'b1; loc_data = 8'h77;
      @(negedge clk);
      chk("full_blocked", 32'(loc_ready), 0);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (loc_ready) got = 1'b1;
      end
      chk("full_pop_ready", 32'(got), 1);
      tick();
      loc_valid = 1'b0;
      chk("full_pop_count", 32'(fifo_count), 16);
      chk("full_pop_head", 32'(putdata), 32'h20);
      wait_idle("full_idle_timeout");

      // 5. collision between an RX byte and a local byte
      recivedata = 8'hC3; rx_start = 1'b1; tick();
      rx_start = 1'b0; tick(); tick();
      loc_valid = 1'b1; loc_data = 8'h55;
      @(negedge clk);
      chk("coll_ready_low", 32'(loc_ready), 0);
      tick();
      @(negedge clk);
      chk("coll_ready_next", 32'(loc_ready), 1);
      tick();
      loc_valid = 1'b0;
      chk("coll_count", 32'(fifo_count), 2);
      wait_fall("coll_fall1", t1); chk("coll_first", 32'(putdata), 32'hC3);
      wait_fall("coll_fall2", t2); chk("coll_second", 32'(putdata), 32'h55);

      // reset asserted mid-WAIT with bytes queued
      tick();
      loc_valid = 1'b1; loc_data = 8'h99; tick();
      loc_data = 8'h9A; tick();
      loc_valid = 1'b0;
      repeat (5) tick();
      chk("pre_rst_busy", 32'(tx_busy), 1);
      chk("pre_rst_count", 32'(fifo_count), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_putdata", 32'(putdata), 32'h00);
      chk("midrst_tx_start", 32'(tx_start), 0);
      chk("midrst_count", 32'(fifo_count), 0);
      chk("midrst_busy", 32'(tx_busy), 0);
      chk("midrst_overflow", 32'(overflow), 0);
      chk("midrst_loc_ready", 32'(loc_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // randomized traffic, three load levels
      for (int i = 0; i < 3000; i++) begin
         int lvl;
         lvl = i / 1000;
         if ($urandom_range(0, 2 + 4 * lvl) == 0) rx_start = ~rx_start;
         recivedata = 8'($urandom);
         loc_valid = ($urandom_range(0, 3 + 8 * lvl) == 0);
         loc_data = 8'($urandom);
         ovf_clr = ($urandom_range(0, 63) == 0);
         tick();
      end
      rx_start = 1'b0; loc_valid = 1'b0; ovf_clr = 1'b0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
